mem_arbiter: RTL

Shares one unified single-ported memory between the processor's instruction-fetch path and its data-memory path. Data and instruction requests arrive as level requests, are arbitrated, and are sequenced onto a ready-handshaked memory port. Each completed access produces a one-cycle Valid pulse. The arbiter sits between the processor top level and the external memory. Its per-port Valid signals drive the pipeline's stall logic.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      IBUSY,
      DBUSY
   } arbState_t;

   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 32;
   localparam int TIMEOUT_LIMIT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one ready-handshaked memory port.
// Optional BUSY watchdog with sticky Timeout output: define MEMARB_TIMEOUT_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DMAX   = 4
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              IReq,
   input  logic [ADDR_W-1:0] IAddr,
   output logic              IValid,
   output logic [DATA_W-1:0] IData,
   input  logic              DReq,
   input  logic              DWrite,
   input  logic [ADDR_W-1:0] DAddr,
   input  logic [DATA_W-1:0] DWData,
   output logic              DValid,
   output logic [DATA_W-1:0] DRData,
`ifdef MEMARB_TIMEOUT_EN
   output logic              Timeout,
`endif
   output logic              MReq,
   output logic              MWrite,
   output logic [ADDR_W-1:0] MAddr,
   output logic [DATA_W-1:0] MWData,
   input  logic              MReady,
   input  logic [DATA_W-1:0] MRData
);

   localparam logic [3:0] DMAX_C = 4'(DMAX);

   arbState_t  state;
   logic [3:0] starveCnt;
   logic       iElig;
   logic       dElig;
   logic       grantD;
   logic       grantI;
   logic       busyExpired;

   // A port whose Valid is high is still holding the request it was just served for.
   assign iElig  = IReq && !IValid;
   assign dElig  = DReq && !DValid;
   assign grantD = (state == IDLE) && dElig && (!iElig || (starveCnt != DMAX_C));
   assign grantI = (state == IDLE) && iElig && !grantD;

`ifdef MEMARB_TIMEOUT_EN
   logic [7:0] wdCnt;

   assign busyExpired = (state != IDLE) && !MReady && (wdCnt == 8'(TIMEOUT_LIMIT - 1));

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         wdCnt   <= '0;
         Timeout <= 1'b0;
      end else begin
         if ((state == IDLE) || MReady || busyExpired) begin
            wdCnt <= '0;
         end else begin
            wdCnt <= wdCnt + 8'd1;
         end
         if (busyExpired) begin
            Timeout <= 1'b1;
         end
      end
   end
`else
   assign busyExpired = 1'b0;
`endif

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state     <= IDLE;
         starveCnt <= '0;
         MReq      <= 1'b0;
         MWrite    <= 1'b0;
         MAddr     <= '0;
         MWData    <= '0;
         IValid    <= 1'b0;
         DValid    <= 1'b0;
         IData     <= '0;
         DRData    <= '0;
      end else begin
         IValid <= 1'b0;
         DValid <= 1'b0;
         case (state)
            IDLE: begin
               if (grantD) begin
                  state  <= DBUSY;
                  MReq   <= 1'b1;
                  MWrite <= DWrite;
                  MAddr  <= DAddr;
                  MWData <= DWData;
                  if (!IReq) begin
                     starveCnt <= '0;
                  end else if (starveCnt < DMAX_C) begin
                     starveCnt <= starveCnt + 4'd1;
                  end
               end else if (grantI) begin
                  state     <= IBUSY;
                  MReq      <= 1'b1;
                  MWrite    <= 1'b0;
                  MAddr     <= IAddr;
                  starveCnt <= '0;
               end
            end
            IBUSY, DBUSY: begin
               // Port outputs hold until the memory completes or the watchdog gives up.
               if (MReady || busyExpired) begin
                  state  <= IDLE;
                  MReq   <= 1'b0;
                  MWrite <= 1'b0;
                  if (state == IBUSY) begin
                     IValid <= 1'b1;
                     IData  <= MReady ? MRData : '0;
                  end else begin
                     DValid <= 1'b1;
                     if (!MReady) begin
                        DRData <= '0;
                     end else if (!MWrite) begin
                        DRData <= MRData;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
